// File: rtl/mmio_initiator.sv
// mmio_initiator
// ----------------------------------------------------------------------------
// Requesting end of the CCI-P MMIO path. It takes simple read/write commands
// from a local controller and issues one MMIO request per command toward an
// AFU register file. Read responses are matched by a 9-bit transaction ID, and
// a read that gets no matching response is abandoned after a bounded wait.
// Typical uses are an on-chip host model for loopback self-test and the
// stimulus source in AFU benches.
//
// Parameters
//   TIMEOUT_CYCLES : number of WAIT cycles before a read is abandoned (2..65535)
//   ADDR_W         : MMIO address width, in 4-byte units
//
// Ports
//   clk, rst       : clock; asynchronous active-high reset
//   cmd_*          : command channel (valid/ready, wr, addr, wdata)
//   mmio_*         : flattened MMIO request (one-cycle write/read valid pulse,
//                    address, tid, write data)
//   rsp_*          : read response from the AFU (valid, tid, data)
//   rd_done        : one-cycle pulse when a read completes or times out
//   rd_data        : read result, valid with rd_done (0 on a timeout)
//   rd_timeout     : qualifies rd_done; 1 = no matching response arrived
//   stray_cnt      : saturating count of responses that matched nothing
//   busy           : the initiator is not idle
// ----------------------------------------------------------------------------
module mmio_initiator #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [63:0]       cmd_wdata,

  output logic              mmio_wr_valid,
  output logic              mmio_rd_valid,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [8:0]        mmio_tid,
  output logic [63:0]       mmio_wdata,

  input  logic              rsp_valid,
  input  logic [8:0]        rsp_tid,
  input  logic [63:0]       rsp_data,

  output logic              rd_done,
  output logic [63:0]       rd_data,
  output logic              rd_timeout,
  output logic [7:0]        stray_cnt,
  output logic              busy
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        req_wr;     // latched direction of the command in flight
  logic [8:0]  tid;        // tid the next / current read uses
  logic [15:0] tmo_cnt;    // WAIT cycles spent without a matching response

  logic        accept;
  logic        rsp_match;
  logic        tmo_hit;

  assign accept    = cmd_valid && (state == IDLE);
  // Only a response that arrives while waiting can complete the read; the
  // same tid seen in IDLE or ISSUE is a leftover from an abandoned read.
  assign rsp_match = (state == WAIT) && rsp_valid && (rsp_tid == tid);
  assign tmo_hit   = (tmo_cnt == TMO_LIMIT);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = req_wr ? IDLE : WAIT;
      end
      WAIT: begin
        // A match in the very cycle the counter reaches the limit still
        // completes with data; both cases leave WAIT the same way.
        if (rsp_match || tmo_hit) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    if (state == IDLE) begin
      cmd_ready = 1'b1;
      busy      = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Request registers. They double as the MMIO request outputs: the valids are
  // set on accept so the request is on the wires for exactly the ISSUE cycle,
  // while address, tid and data simply hold until the next accept.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_wr        <= 1'b0;
      mmio_wr_valid <= 1'b0;
      mmio_rd_valid <= 1'b0;
      mmio_addr     <= '0;
      mmio_tid      <= '0;
      mmio_wdata    <= '0;
    end else begin
      mmio_wr_valid <= accept && cmd_wr;
      mmio_rd_valid <= accept && !cmd_wr;
      if (accept) begin
        req_wr     <= cmd_wr;
        mmio_addr  <= cmd_addr;
        mmio_wdata <= cmd_wdata;
        // Writes carry the current tid but do not consume it.
        mmio_tid   <= tid;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Timeout counter: cleared on the way into WAIT, then counts every WAIT
  // cycle that neither matches nor has already reached the limit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == ISSUE) begin
      tmo_cnt <= '0;
    end else if ((state == WAIT) && !rsp_match && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Read completion and tid allocation. The tid advances only when a read
  // leaves WAIT, and wraps naturally at 9 bits.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_done    <= 1'b0;
      rd_timeout <= 1'b0;
      rd_data    <= '0;
      tid        <= '0;
    end else begin
      rd_done    <= 1'b0;
      rd_timeout <= 1'b0;
      if (rsp_match) begin
        rd_done <= 1'b1;
        rd_data <= rsp_data;
        tid     <= tid + 9'd1;
      end else if ((state == WAIT) && tmo_hit) begin
        rd_done    <= 1'b1;
        rd_timeout <= 1'b1;
        rd_data    <= '0;
        tid        <= tid + 9'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stray response counter: any response that does not complete the current
  // read, in any state, saturating at 255.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stray_cnt <= '0;
    end else if (rsp_valid && !rsp_match && (stray_cnt != 8'hFF)) begin
      stray_cnt <= stray_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mmio_initiator.sv
// Testbench for mmio_initiator: directed scenarios followed by randomized
// traffic, all checked every cycle against a transaction-timeline model.
module tb_mmio_initiator;

  localparam int T  = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [63:0]   cmd_wdata = '0;
  logic          rsp_valid = 1'b0;
  logic [8:0]    rsp_tid = '0;
  logic [63:0]   rsp_data = '0;

  logic          cmd_ready;
  logic          mmio_wr_valid;
  logic          mmio_rd_valid;
  logic [AW-1:0] mmio_addr;
  logic [8:0]    mmio_tid;
  logic [63:0]   mmio_wdata;
  logic          rd_done;
  logic [63:0]   rd_data;
  logic          rd_timeout;
  logic [7:0]    stray_cnt;
  logic          busy;

  always #5 clk = ~clk;

  mmio_initiator #(.TIMEOUT_CYCLES(T), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .rd_done(rd_done), .rd_data(rd_data), .rd_timeout(rd_timeout),
    .stray_cnt(stray_cnt), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Model: a timeline of edges. free_edge is the first edge at which a command
  // can be taken; a pending read issued at edge rd_a may be answered at edges
  // rd_a+2 .. rd_a+T+2, the last of which is also its timeout edge.
  int         n;
  int         free_edge;
  int         rd_a;
  bit         pend;
  logic [8:0] m_tid;
  int         m_stray;

  logic          e_ready, e_busy, e_wr, e_rd, e_done, e_to;
  logic [AW-1:0] e_addr;
  logic [8:0]    e_tid;
  logic [63:0]   e_wdata, e_data;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp, n);
    end
  endfunction

  function automatic void model_reset();
    n = 0; free_edge = 0; rd_a = 0; pend = 0; m_tid = '0; m_stray = 0;
    e_ready = 1; e_busy = 0; e_wr = 0; e_rd = 0; e_done = 0; e_to = 0;
    e_addr = '0; e_tid = '0; e_wdata = '0; e_data = '0;
  endfunction

  // Predicts the outputs seen just after edge n from the inputs sampled at n.
  function automatic void model_edge();
    bit matched, timedout;
    e_wr = 0; e_rd = 0; e_done = 0; e_to = 0;
    matched  = pend && rsp_valid && (rsp_tid == m_tid) &&
               (n >= rd_a + 2) && (n <= rd_a + T + 2);
    timedout = pend && !matched && (n == rd_a + T + 2);
    if (rsp_valid && !matched && m_stray < 255) m_stray++;
    if (matched || timedout) begin
      e_done = 1;
      e_to   = timedout;
      e_data = matched ? rsp_data : 64'd0;
      m_tid  = m_tid + 9'd1;
      pend   = 0;
      free_edge = n + 1;
      $display("read done  edge=%0d data=%h timeout=%0d", n, e_data, e_to);
    end
    if (cmd_valid && n >= free_edge) begin
      e_wr = cmd_wr; e_rd = !cmd_wr;
      e_addr = cmd_addr; e_wdata = cmd_wdata; e_tid = m_tid;
      if (cmd_wr) free_edge = n + 2;
      else begin pend = 1; rd_a = n; free_edge = 32'h7fffffff; end
      $display("cmd accept edge=%0d wr=%0d addr=%h data=%h tid=%0d",
               n, cmd_wr, cmd_addr, cmd_wdata, m_tid);
    end
    e_ready = (n + 1 >= free_edge);
    e_busy  = !e_ready;
  endfunction

  function automatic void check_all();
    chk("cmd_ready", 64'(cmd_ready), 64'(e_ready));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("mmio_wr_valid", 64'(mmio_wr_valid), 64'(e_wr));
    chk("mmio_rd_valid", 64'(mmio_rd_valid), 64'(e_rd));
    if (e_wr || e_rd) begin
      chk("mmio_addr", 64'(mmio_addr), 64'(e_addr));
      chk("mmio_tid", 64'(mmio_tid), 64'(e_tid));
    end
    chk("mmio_wdata", mmio_wdata, e_wdata);
    chk("rd_done", 64'(rd_done), 64'(e_done));
    if (e_done) begin
      chk("rd_data", rd_data, e_data);
      chk("rd_timeout", 64'(rd_timeout), 64'(e_to));
    end
    chk("stray_cnt", 64'(stray_cnt), 64'(m_stray));
  endfunction

  task automatic step(input logic cv, input logic wr, input logic [AW-1:0] a,
                      input logic [63:0] wd, input logic rv,
                      input logic [8:0] rt, input logic [63:0] rdat);
    @(negedge clk);
    cmd_valid = cv; cmd_wr = wr; cmd_addr = a; cmd_wdata = wd;
    rsp_valid = rv; rsp_tid = rt; rsp_data = rdat;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    n++;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] last_wr;
    int k, pulses, guard;
    model_reset();

    // Reset state while rst is held
    #12;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valids", {62'd0, mmio_wr_valid, mmio_rd_valid}, 64'd0);
    chk("rst_addr_tid", {mmio_addr, mmio_tid}, 64'd0);
    chk("rst_wdata", mmio_wdata, 64'd0);
    chk("rst_rd", {rd_done, rd_timeout, rd_data[61:0]}, 64'd0);
    chk("rst_stray", 64'(stray_cnt), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Write 0x20
    last_wr = 64'hDEADBEEF_CAFEF00D;
    step(1, 1, 16'h0020, last_wr, 0, '0, '0);
    chk("wr_pulse", 64'(mmio_wr_valid), 64'd1);
    chk("wr_no_rd", 64'(mmio_rd_valid), 64'd0);
    chk("wr_addr", 64'(mmio_addr), 64'h20);
    chk("wr_data", mmio_wdata, 64'hDEADBEEF_CAFEF00D);
    chk("wr_busy", 64'(busy), 64'd1);
    idle();
    chk("wr_busy_end", 64'(busy), 64'd0);
    chk("wr_pulse_end", 64'(mmio_wr_valid), 64'd0);

    // Read 0x20 with a single-cycle responder returning the last write
    step(1, 0, 16'h0020, '0, 0, '0, '0);
    chk("rd0_tid", 64'(mmio_tid), 64'd0);
    idle();
    step(0, 0, '0, '0, 1, 9'd0, last_wr);
    chk("rd0_done", 64'(rd_done), 64'd1);
    chk("rd0_data", rd_data, 64'hDEADBEEF_CAFEF00D);
    chk("rd0_to", 64'(rd_timeout), 64'd0);

    // Silent responder: timeout T+2 edges after accept
    step(1, 0, 16'h0024, '0, 0, '0, '0);
    chk("rd1_tid", 64'(mmio_tid), 64'd1);
    for (int i = 1; i <= T + 2; i++) begin
      idle();
      if (i == T + 2) begin
        chk("tmo_done", 64'(rd_done), 64'd1);
        chk("tmo_flag", 64'(rd_timeout), 64'd1);
        chk("tmo_data", rd_data, 64'd0);
      end else begin
        chk("tmo_early", 64'(rd_done), 64'd0);
      end
    end
    step(0, 0, '0, '0, 1, 9'd0, 64'h55);
    chk("late_stray", 64'(stray_cnt), 64'd1);

    // Wrong tid then matching tid
    step(1, 0, 16'h0030, '0, 0, '0, '0);
    chk("rd2_tid", 64'(mmio_tid), 64'd2);
    idle();
    step(0, 0, '0, '0, 1, 9'd5, 64'h9999);
    chk("inj_stray", 64'(stray_cnt), 64'd2);
    step(0, 0, '0, '0, 1, 9'd2, 64'h1234);
    chk("inj_done", 64'(rd_done), 64'd1);
    chk("inj_data", rd_data, 64'h1234);

    // Randomized traffic (drives stray_cnt into saturation as well)
    for (int i = 0; i < 3000; i++) begin
      logic [8:0] rt;
      rt = ($urandom % 2 == 0) ? m_tid : 9'($urandom % 512);
      step(1'($urandom % 2), 1'($urandom % 3 == 0), AW'($urandom),
           {$urandom, $urandom}, 1'($urandom % 100 < 15), rt,
           {$urandom, $urandom});
    end

    // Drain, then reset in the middle of a WAIT
    guard = 0;
    while ((pend || n < free_edge) && guard < 50) begin idle(); guard++; end
    chk("drain_bound", 64'(guard < 50), 64'd1);
    step(1, 0, 16'h0040, '0, 0, '0, '0);
    idle();
    idle();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_valids", {62'd0, mmio_wr_valid, mmio_rd_valid}, 64'd0);
    chk("arst_addr_tid", {mmio_addr, mmio_tid}, 64'd0);
    chk("arst_wdata", mmio_wdata, 64'd0);
    chk("arst_rd", {rd_done, rd_timeout, rd_data[61:0]}, 64'd0);
    chk("arst_stray", 64'(stray_cnt), 64'd0);
    model_reset();
    cmd_valid = 0; rsp_valid = 0;
    @(posedge clk); #1 rst = 1'b0;
    step(0, 0, '0, '0, 1, 9'd3, 64'h77);
    chk("arst_late_stray", 64'(stray_cnt), 64'd1);

    // 513 back-to-back reads, cmd_valid held, single-cycle responder
    k = 0; pulses = 0; guard = 0;
    while ((k < 513 || pend) && guard < 2500) begin
      step(k < 513, 0, AW'(k), '0, pend && (n == rd_a + 2), m_tid, 64'(k));
      if (mmio_rd_valid) pulses++;
      if (e_rd) begin
        chk("seq_tid", 64'(mmio_tid), 64'(k % 512));
        k++;
      end
      guard++;
    end
    chk("seq_bound", 64'(guard < 2500), 64'd1);
    chk("seq_pulses", 64'(pulses), 64'd513);
    chk("seq_cycles", 64'(guard), 64'd1539);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
